// File: rtl/adc_cfg_sequencer.sv
// adc_cfg_sequencer: ADC344x reset pulse + SPI register-table bring-up.
// Optional verify pass: define ADC_CFG_READBACK_EN.
module adc_cfg_sequencer #(
  parameter int C_SclkDiv     = 4,
  parameter int C_RstPulseCyc = 100,
  parameter int C_RstWaitCyc  = 1000,
  parameter int C_CsGapCyc    = 8,
  parameter int C_TblDepth    = 16,
  parameter int C_AutoStart   = 1
) (
  input  logic        SysClk,
  input  logic        SysRst_n,
  input  logic        CfgStart,
  output logic [7:0]  TblAddr,
  input  logic [19:0] TblData,
  output logic        ADC_SCLK,
  output logic        ADC_CS,
  output logic        ADC_MOSI,
  input  logic        ADC_MISO,
  output logic        ADC_RESET,
  output logic        ADC_PDN,
  output logic        AdcIntrfcRst,
  output logic        CfgBusy,
  output logic        CfgDone,
  output logic        CfgErr,
  output logic [7:0]  ErrIdx
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_PULSE, S_RST_WAIT,
    S_FETCH, S_SHIFT, S_GAP, S_DONE
  } state_t;

  localparam int CW = 20;
  localparam logic [CW-1:0] L_PULSE = CW'(C_RstPulseCyc - 1);
  localparam logic [CW-1:0] L_WAIT  = CW'(C_RstWaitCyc - 1);
  localparam logic [CW-1:0] L_HALF  = CW'(C_SclkDiv - 1);
  localparam logic [CW-1:0] L_GAP   = CW'(C_CsGapCyc - 1);
  localparam logic [7:0]    L_LAST  = 8'(C_TblDepth - 1);
  localparam logic [5:0]    L_PHEND = 6'd49;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [5:0]      r_ph;
  logic [22:0]     r_sh;
  logic            r_fw;
  logic            r_auto;
  logic            r_sclk;
  logic            r_cs;
  logic            r_mosi;
  logic            r_rst;
  logic            r_irst;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_addr;

  logic            w_vfy;
  logic            w_start;
  logic            w_load;
  logic [23:0]     w_frame;
  logic [5:0]      w_ph_nx;

`ifdef ADC_CFG_READBACK_EN
  localparam logic [5:0] L_PHRD = 6'd33;
  logic            r_vfy;
  logic [7:0]      r_exp;
  logic [7:0]      r_rd;
  logic            r_err;
  logic [7:0]      r_eidx;
  assign w_vfy  = r_vfy;
  assign CfgErr = r_err;
  assign ErrIdx = r_eidx;
`else
  logic            w_unused;
  assign w_vfy    = 1'b0;
  assign CfgErr   = 1'b0;
  assign ErrIdx   = 8'h00;
  assign w_unused = ADC_MISO;
`endif

  assign w_start = ((r_state == S_IDLE) || (r_state == S_DONE))
                 && (CfgStart || r_auto);
  // Entry 0's address has been stable since start, so its fetch
  // folds into the last wait cycle and CS falls exactly on time.
  assign w_load  = ((r_state == S_RST_WAIT) && (r_cnt == L_WAIT))
                 || ((r_state == S_FETCH) && r_fw);
  assign w_frame = w_vfy ? {4'b1000, TblData[19:8], 8'h00}
                         : {4'b0000, TblData};
  assign w_ph_nx = r_ph + 6'd1;

  assign TblAddr      = r_addr;
  assign ADC_SCLK     = r_sclk;
  assign ADC_CS       = r_cs;
  assign ADC_MOSI     = r_mosi;
  assign ADC_RESET    = r_rst;
  assign ADC_PDN      = 1'b0;
  assign AdcIntrfcRst = r_irst;
  assign CfgBusy      = r_busy;
  assign CfgDone      = r_done;

  // Sequencer FSM with registered SPI and status outputs.
  always_ff @(posedge SysClk or negedge SysRst_n) begin
    if (!SysRst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ph    <= '0;
      r_sh    <= '0;
      r_fw    <= 1'b0;
      r_auto  <= (C_AutoStart != 0);
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_mosi  <= 1'b0;
      r_rst   <= 1'b0;
      r_irst  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
`ifdef ADC_CFG_READBACK_EN
      r_vfy   <= 1'b0;
      r_exp   <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
      r_eidx  <= '0;
`endif
    end else begin
      r_auto <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state <= S_RST_PULSE;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_irst  <= 1'b1;
            r_addr  <= '0;
            r_rst   <= 1'b1;
`ifdef ADC_CFG_READBACK_EN
            r_vfy   <= 1'b0;
            r_err   <= 1'b0;
            r_eidx  <= '0;
`endif
          end
        end
        S_RST_PULSE: begin
          if (r_cnt == L_PULSE) begin
            r_rst   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RST_WAIT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RST_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
        end
        S_FETCH: begin
          r_fw <= 1'b1;
        end
        S_SHIFT: begin
          if (r_cnt != L_HALF) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= '0;
            r_ph  <= w_ph_nx;
            if (w_ph_nx == L_PHEND) begin
              r_cs    <= 1'b1;
              r_mosi  <= 1'b0;
              r_state <= S_GAP;
`ifdef ADC_CFG_READBACK_EN
              if (r_vfy && (r_rd != r_exp) && !r_err) begin
                r_err  <= 1'b1;
                r_eidx <= r_addr;
              end
`endif
            end else if (w_ph_nx[0]) begin
              r_sclk <= 1'b1;
`ifdef ADC_CFG_READBACK_EN
              if (w_ph_nx >= L_PHRD)
                r_rd <= {r_rd[6:0], ADC_MISO};
`endif
            end else begin
              r_sclk <= 1'b0;
              r_mosi <= r_sh[22];
              r_sh   <= {r_sh[21:0], 1'b0};
            end
          end
        end
        S_GAP: begin
          if (r_cnt != L_GAP) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= '0;
            r_fw  <= 1'b0;
            if (r_addr != L_LAST) begin
              r_addr  <= r_addr + 8'd1;
              r_state <= S_FETCH;
            end
`ifdef ADC_CFG_READBACK_EN
            else if (!r_vfy) begin
              r_vfy   <= 1'b1;
              r_addr  <= '0;
              r_state <= S_FETCH;
            end
`endif
            else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_irst  <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_load) begin
        r_state <= S_SHIFT;
        r_cnt   <= '0;
        r_ph    <= '0;
        r_cs    <= 1'b0;
        r_mosi  <= w_frame[23];
        r_sh    <= w_frame[22:0];
`ifdef ADC_CFG_READBACK_EN
        r_exp   <= TblData[7:0];
`endif
      end
    end
  end

endmodule
